pam4_tx_source: RTL and testbench

- Transmit-side symbol source for the 4-ASK MER test path.
- Generates pseudo-random 2-bit symbols from an LFSR and Gray-maps them to signed 18-bit levels.
- Emits a zero-stuffed sample stream, at the sample rate, for the pulse-shaping filter.
- Also provides a delay-matched reference symbol and a clear_accum period marker for the receive-side slicer/error checker.

---
 rtl/pam4_pkg.sv | 47 ++++
 rtl/pam4_tx_source_if.sv | 26 ++
 rtl/lfsr_gen.sv | 27 ++
 rtl/pam4_tx_source.sv | 142 ++++++++++++++
 tb/tb_pam4_tx_source.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pam4_pkg.sv
// Shared 4-ASK definitions: symbol codes, Gray level map and 1s17 level format.
// The receive-side slicer imports this package so both ends agree on the mapping.
package pam4_pkg;

  localparam int LVL_W    = 18;
  localparam int LVL_FRAC = 17;
  localparam int PROD_W   = 20;

  typedef logic signed [LVL_W-1:0] level_t;

  localparam level_t AMP_DEFAULT = 18'sd21845;

  typedef enum logic [1:0] {
    SYM_N3 = 2'b00,
    SYM_N1 = 2'b01,
    SYM_P1 = 2'b11,
    SYM_P3 = 2'b10
  } sym_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [1:0] sym;
    level_t     level;
    logic       clr;
  } tx_sym_t;

  // Products are formed at PROD_W bits and truncated back to the 1s17 level width.
  function automatic level_t gray_map(input logic [1:0] sym, input level_t amp);
    logic signed [PROD_W-1:0] a1;
    logic signed [PROD_W-1:0] a3;
    logic signed [PROD_W-1:0] p;
    a1 = PROD_W'(amp);
    a3 = a1 + (a1 <<< 1);
    case (sym_e'(sym))
      SYM_N3:  p = -a3;
      SYM_N1:  p = -a1;
      SYM_P1:  p = a1;
      default: p = a3;
    endcase
    return level_t'(p[LVL_W-1:0]);
  endfunction

endpackage

// File: rtl/pam4_tx_source_if.sv
// Handshake/data bundle between the symbol source and its consumers.
// master = symbol source, slave = enable generator / receive-side checker.
interface pam4_tx_source_if;
  import pam4_pkg::*;

  logic       sym_clk_en;
  logic       smp_clk_en;
  logic       enable;
  logic       running;
  logic [1:0] sym_out;
  level_t     tx_level;
  level_t     tx_sample;
  logic [1:0] sym_ref;
  logic       clear_accum;
  logic       align_err;

  modport master (
    input  sym_clk_en, smp_clk_en, enable,
    output running, sym_out, tx_level, tx_sample, sym_ref, clear_accum, align_err
  );

  modport slave (
    output sym_clk_en, smp_clk_en, enable,
    input  running, sym_out, tx_level, tx_sample, sym_ref, clear_accum, align_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci-style LFSR: shifts left, feedback is the XOR of the tapped bits.
// Load wins over step so a stop/restart always lands back on SEED.
module lfsr_gen #(
  parameter int                LFSR_W = 22,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(22'h200001),
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(22'h000001)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_step,
  input  logic              i_load,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb   = ^(r_lfsr & TAPS);
  assign o_lfsr = r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_lfsr <= SEED;
    else if (i_load) r_lfsr <= SEED;
    else if (i_step) r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
  end

endmodule

// File: rtl/pam4_tx_source.sv
// 4-ASK transmit symbol source: LFSR symbols, Gray-mapped levels, zero-stuffed
// sample stream, delay-matched reference symbol and symbol/sample alignment monitor.
module pam4_tx_source
  import pam4_pkg::*;
#(
  parameter int                LFSR_W    = 22,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(22'h200001),
  parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(22'h000001),
  parameter level_t            AMP       = AMP_DEFAULT,
  parameter int                UPSAMPLE  = 4,
  parameter int                REF_DELAY = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  pam4_tx_source_if.master bus
);

  localparam int              PH_W    = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);

  tx_state_e r_state;
  tx_state_e w_state_nxt;
  logic      w_sym_en;
  logic      w_smp_en;
  logic      w_step;
  logic      w_load;

  logic [LFSR_W-1:0] w_lfsr;
  logic [1:0]        w_cur_sym;
  level_t            w_cur_lvl;
  tx_sym_t           w_sym_nxt;
  tx_sym_t           r_sym;
  level_t            r_smp;

  logic [REF_DELAY-1:0][1:0] r_dl;
  logic [1:0]                r_ref;

  logic [PH_W-1:0] r_phase;
  logic            r_seen_sym;
  logic            r_align_err;

  assign w_sym_en  = bus.sym_clk_en;
  assign w_smp_en  = bus.smp_clk_en;
  assign w_cur_sym = w_lfsr[1:0];
  assign w_cur_lvl = gray_map(w_cur_sym, AMP);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Only the value of enable on a symbol strobe matters; in between it is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sym_en && bus.enable) begin
          w_state_nxt = ST_RUN;
          w_step      = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_sym_en) begin
          if (bus.enable) begin
            w_step = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_load      = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  lfsr_gen #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_reset),
    .i_step  (w_step),
    .i_load  (w_load),
    .o_lfsr  (w_lfsr)
  );

  always_comb begin
    w_sym_nxt = '0;
    if (w_step) begin
      w_sym_nxt.sym   = w_cur_sym;
      w_sym_nxt.level = w_cur_lvl;
      w_sym_nxt.clr   = (w_lfsr == SEED);
    end
  end

  // Reference path: REF_DELAY-deep line plus an output stage, so sym_ref
  // trails sym_out by exactly REF_DELAY symbols.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sym <= '0;
      r_dl  <= '0;
      r_ref <= '0;
    end else if (w_sym_en) begin
      r_sym   <= w_sym_nxt;
      r_dl[0] <= w_sym_nxt.sym;
      for (int i = 1; i < REF_DELAY; i++) r_dl[i] <= r_dl[i-1];
      r_ref   <= r_dl[REF_DELAY-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)      r_smp <= '0;
    else if (w_smp_en) r_smp <= w_step ? w_cur_lvl : '0;
  end

  // The very first strobe after reset defines the phase, so it cannot be late.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_phase     <= '0;
      r_seen_sym  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      if (w_smp_en) r_phase <= (w_sym_en || r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
      if (w_sym_en) begin
        r_seen_sym <= 1'b1;
        if (!w_smp_en || (r_seen_sym && r_phase != PH_LAST)) r_align_err <= 1'b1;
      end
    end
  end

  assign bus.running     = (r_state == ST_RUN);
  assign bus.sym_out     = r_sym.sym;
  assign bus.tx_level    = r_sym.level;
  assign bus.clear_accum = r_sym.clr;
  assign bus.tx_sample   = r_smp;
  assign bus.sym_ref     = r_ref;
  assign bus.align_err   = r_align_err;

endmodule

// File: tb/tb_pam4_tx_source.sv
// Bench for pam4_tx_source with a 4-bit LFSR (period 15): symbol-level model
// checked every cycle, plus literal expectations from hand-worked sequences.
module tb_pam4_tx_source;
  import pam4_pkg::*;

  localparam int              LW  = 4;
  localparam logic [LW-1:0]   TP  = 4'b1100;
  localparam logic [LW-1:0]   SD  = 4'b0001;
  localparam level_t          AM  = 18'sd21845;
  localparam int              A   = 21845;
  localparam int              UP  = 4;
  localparam int              RD  = 3;
  localparam int              PER = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pam4_tx_source_if bus ();

  pam4_tx_source #(
    .LFSR_W(LW), .TAPS(TP), .SEED(SD), .AMP(AM), .UPSAMPLE(UP), .REF_DELAY(RD)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Symbol sequence straight from the LFSR rule, and the Gray level table.
  int seq [PER];
  function automatic int lvl_of(input int s);
    case (s)
      0:       return -3 * A;
      1:       return -A;
      3:       return A;
      default: return 3 * A;
    endcase
  endfunction

  int  m_k = 0, m_sym = 0, m_lvl = 0, m_smp = 0, m_ref = 0, m_gap = 0, m_new = 0;
  bit  m_run = 0, m_clr = 0, m_err = 0, m_seen = 0;
  int  m_q [$];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_k = 0; m_sym = 0; m_lvl = 0; m_smp = 0; m_ref = 0; m_gap = 0;
      m_run = 0; m_clr = 0; m_err = 0; m_seen = 0;
      m_q.delete();
    end else begin
      if (bus.sym_clk_en) begin
        if (!bus.smp_clk_en || (m_seen && (m_gap % UP) != UP - 1)) m_err = 1;
        m_seen = 1;
      end
      if (bus.smp_clk_en) begin
        m_gap = bus.sym_clk_en ? 0 : m_gap + 1;
        m_smp = (bus.sym_clk_en && bus.enable) ? lvl_of(seq[m_k]) : 0;
      end
      if (bus.sym_clk_en) begin
        if (bus.enable) begin
          m_new = seq[m_k];
          m_clr = (m_k == 0);
          m_k   = (m_k + 1) % PER;
          m_run = 1;
          m_sym = m_new;
          m_lvl = lvl_of(m_new);
        end else begin
          m_new = 0; m_sym = 0; m_lvl = 0; m_clr = 0; m_k = 0; m_run = 0;
        end
        m_q.push_back(m_new);
        if (m_q.size() > RD) m_ref = m_q.pop_front();
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("running",     bus.running,     m_run);
    chk("sym_out",     bus.sym_out,     m_sym);
    chk("tx_level",    bus.tx_level,    m_lvl);
    chk("tx_sample",   bus.tx_sample,   m_smp);
    chk("sym_ref",     bus.sym_ref,     m_ref);
    chk("clear_accum", bus.clear_accum, m_clr);
    chk("align_err",   bus.align_err,   m_err);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // One symbol period: strobe, then three plain samples; optional enable glitch mid-period.
  task automatic do_sym(input bit glitch, output logic [1:0] s, output level_t l, output logic c,
                        output logic [1:0] r, output logic run, output level_t t0, output level_t t1);
    @(negedge clk); bus.sym_clk_en = 1'b1; bus.smp_clk_en = 1'b1;
    @(negedge clk); bus.sym_clk_en = 1'b0;
    s = bus.sym_out; l = bus.tx_level; c = bus.clear_accum; r = bus.sym_ref;
    run = bus.running; t0 = bus.tx_sample;
    @(negedge clk); t1 = bus.tx_sample;
    if (glitch) bus.enable = ~bus.enable;
    @(negedge clk);
    if (glitch) bus.enable = ~bus.enable;
  endtask

  logic [1:0] e_s [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
  int         e_l [4] = '{-21845, 65535, -65535, -21845};

  initial begin
    logic [1:0] s, r;
    level_t     l, t0, t1;
    logic       c, run;
    int         st, fb;

    st = 1;
    for (int i = 0; i < PER; i++) begin
      seq[i] = st & 3;
      fb     = ((st >> 3) ^ (st >> 2)) & 1;
      st     = ((st << 1) | fb) & 15;
    end
    chk("model_seq0", seq[0], 1);
    chk("model_seq1", seq[1], 2);
    chk("model_seq2", seq[2], 0);
    chk("model_seq3", seq[3], 1);

    bus.sym_clk_en = 1'b0; bus.smp_clk_en = 1'b0; bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_running", bus.running, 0);
    chk("rst_sym", bus.sym_out, 0);
    chk("rst_sample", bus.tx_sample, 0);
    chk("rst_align", bus.align_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++) begin
      do_sym(1'b0, s, l, c, r, run, t0, t1);
      chk("idle_running", run, 0);
      chk("idle_sym", s, 0);
      chk("idle_sample", t0, 0);
    end

    // Scenarios 1-3: start, 31 symbols, samples and reference path.
    bus.enable = 1'b1;
    for (int i = 0; i < 31; i++) begin
      do_sym(1'b0, s, l, c, r, run, t0, t1);
      if (i < 4) begin
        chk("first_sym", s, e_s[i]);
        chk("first_lvl", l, e_l[i]);
        chk("first_running", run, 1);
      end
      chk("seq_sym", s, seq[i % PER]);
      chk("clear_idx", c, (i % PER) == 0);
      chk("stuff_lvl", t0, lvl_of(seq[i % PER]));
      chk("stuff_zero", t1, 0);
      chk("ref_delay", r, (i < RD) ? 0 : seq[(i - RD) % PER]);
    end

    // Scenario 4: stop mid-period, enable glitches ignored, deterministic restart.
    bus.enable = 1'b0;
    do_sym(1'b0, s, l, c, r, run, t0, t1);
    chk("stop_sym", s, 0);
    chk("stop_lvl", l, 0);
    chk("stop_clear", c, 0);
    chk("stop_running", run, 0);
    do_sym(1'b1, s, l, c, r, run, t0, t1);
    chk("idle_glitch_running", run, 0);
    bus.enable = 1'b1;
    do_sym(1'b1, s, l, c, r, run, t0, t1);
    chk("restart_sym", s, 1);
    chk("restart_lvl", l, -21845);
    chk("restart_clear", c, 1);
    chk("restart_running", run, 1);
    do_sym(1'b0, s, l, c, r, run, t0, t1);
    chk("run_glitch_sym", s, 2);
    chk("align_before", bus.align_err, 0);

    // Scenario 5: strobe after only two samples.
    @(negedge clk); bus.sym_clk_en = 1'b1;
    @(negedge clk); bus.sym_clk_en = 1'b0;
    @(negedge clk); bus.sym_clk_en = 1'b1;
    @(negedge clk); bus.sym_clk_en = 1'b0;
    chk("align_set", bus.align_err, 1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) do_sym(1'b0, s, l, c, r, run, t0, t1);
    chk("align_sticky", bus.align_err, 1);

    // Scenario 6: asynchronous reset between edges while running.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_running", bus.running, 0);
    chk("arst_sym", bus.sym_out, 0);
    chk("arst_lvl", bus.tx_level, 0);
    chk("arst_ref", bus.sym_ref, 0);
    chk("arst_align", bus.align_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_sym(1'b0, s, l, c, r, run, t0, t1);
      chk("again_sym", s, e_s[i]);
      chk("again_lvl", l, e_l[i]);
    end
    chk("again_align", bus.align_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
